// File: rtl/ysyx_25020042_wbu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020042_wbu_pkg
// Brief    : Shared core widths, commit-counter width and writeback arbitration.
// Revision : 1.0  initial release
// ============================================================================
package ysyx_25020042_wbu_pkg;

   localparam int WBU_REG_ADDR_LEN = 5;
   localparam int WBU_WIDTH        = 32;
   localparam int WBU_REGS         = 32;
   localparam int WBU_CNT_W        = 32;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_LSU  = 2'd1,
      SRC_EXU  = 2'd2
   } wb_src_e;

   // Loads always win; the EXU sees ready low while a load is offered.
   function automatic wb_src_e wb_arbitrate(input logic lsu_valid, input logic exu_valid);
      if (lsu_valid)
         return SRC_LSU;
      else if (exu_valid)
         return SRC_EXU;
      else
         return SRC_NONE;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_25020042_wbu_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020042_wbu_if
// Brief    : Writeback bundle: EXU/LSU handshakes, issue/hazard query, GPR port.
// Revision : 1.0  initial release
// ============================================================================
interface ysyx_25020042_wbu_if
   import ysyx_25020042_wbu_pkg::*;
#(
   parameter int REG_ADDR_LEN = WBU_REG_ADDR_LEN,
   parameter int WIDTH        = WBU_WIDTH
);
   logic                    exu_valid;
   logic                    exu_ready;
   logic [REG_ADDR_LEN-1:0] exu_rd;
   logic [WIDTH-1:0]        exu_data;
   logic                    lsu_valid;
   logic                    lsu_ready;
   logic [REG_ADDR_LEN-1:0] lsu_rd;
   logic [WIDTH-1:0]        lsu_data;
   logic                    iss_valid;
   logic [REG_ADDR_LEN-1:0] iss_rd;
   logic [REG_ADDR_LEN-1:0] rs1;
   logic [REG_ADDR_LEN-1:0] rs2;
   logic                    rs1_busy;
   logic                    rs2_busy;
   logic [REG_ADDR_LEN-1:0] gpr_rd;
   logic [WIDTH-1:0]        gpr_wdata;
   logic                    wb_commit;
   logic [WBU_CNT_W-1:0]    commit_cnt;

   modport slave (
      input  exu_valid, exu_rd, exu_data,
      input  lsu_valid, lsu_rd, lsu_data,
      input  iss_valid, iss_rd, rs1, rs2,
      output exu_ready, lsu_ready, rs1_busy, rs2_busy,
      output gpr_rd, gpr_wdata, wb_commit, commit_cnt
   );

   modport master (
      output exu_valid, exu_rd, exu_data,
      output lsu_valid, lsu_rd, lsu_data,
      output iss_valid, iss_rd, rs1, rs2,
      input  exu_ready, lsu_ready, rs1_busy, rs2_busy,
      input  gpr_rd, gpr_wdata, wb_commit, commit_cnt
   );

endinterface
`default_nettype wire

// File: rtl/ysyx_25020042_wbu_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020042_scoreboard
// Brief    : Pending-write busy vector with bypassed source-hazard query.
// Revision : 1.0  initial release
// ============================================================================
module ysyx_25020042_scoreboard
   import ysyx_25020042_wbu_pkg::*;
#(
   parameter int REG_ADDR_LEN = WBU_REG_ADDR_LEN,
   parameter int REGS         = WBU_REGS
)(
   input  wire logic                    clk,
   input  wire logic                    rst,
   input  wire logic                    i_set_valid,
   input  wire logic [REG_ADDR_LEN-1:0] i_set_idx,
   input  wire logic                    i_clr_valid,
   input  wire logic [REG_ADDR_LEN-1:0] i_clr_idx,
   input  wire logic [REG_ADDR_LEN-1:0] i_rs1,
   input  wire logic [REG_ADDR_LEN-1:0] i_rs2,
   output      logic                    o_rs1_busy,
   output      logic                    o_rs2_busy
);

   logic [REGS-1:0] r_busy;
   logic [REGS-1:0] w_set_mask;
   logic [REGS-1:0] w_clr_mask;
   logic            w_rs1_hit;
   logic            w_rs2_hit;

   // Decode starts at 1 so x0 can never become busy.
   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      w_rs1_hit  = 1'b0;
      w_rs2_hit  = 1'b0;
      for (int i = 1; i < REGS; i++) begin
         if (i_set_valid && (i_set_idx == REG_ADDR_LEN'(i)))
            w_set_mask[i] = 1'b1;
         if (i_clr_valid && (i_clr_idx == REG_ADDR_LEN'(i)))
            w_clr_mask[i] = 1'b1;
         if (i_rs1 == REG_ADDR_LEN'(i))
            w_rs1_hit = r_busy[i];
         if (i_rs2 == REG_ADDR_LEN'(i))
            w_rs2_hit = r_busy[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_busy <= '0;
      else
         r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
   end

   // A write committing this cycle already resolves the hazard.
   assign o_rs1_busy = w_rs1_hit & ~(i_clr_valid && (i_clr_idx == i_rs1));
   assign o_rs2_busy = w_rs2_hit & ~(i_clr_valid && (i_clr_idx == i_rs2));

endmodule
`default_nettype wire

// File: rtl/ysyx_25020042_wbu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020042_wbu
// Brief    : Writeback unit: LSU-priority arbitration, registered GPR write stage.
// Revision : 1.0  initial release
// ============================================================================
module ysyx_25020042_wbu
   import ysyx_25020042_wbu_pkg::*;
#(
   parameter int REG_ADDR_LEN = WBU_REG_ADDR_LEN,
   parameter int WIDTH        = WBU_WIDTH,
   parameter int REGS         = WBU_REGS
)(
   input wire logic clk,
   input wire logic rst,
   ysyx_25020042_wbu_if.slave bus
);

   wb_src_e                 w_src;
   logic                    w_fire;
   logic [REG_ADDR_LEN-1:0] w_rd;
   logic [WIDTH-1:0]        w_data;

   logic                    r_wb_commit;
   logic [REG_ADDR_LEN-1:0] r_gpr_rd;
   logic [WIDTH-1:0]        r_gpr_wdata;
   logic [WBU_CNT_W-1:0]    r_commit_cnt;

   assign bus.lsu_ready = 1'b1;
   assign bus.exu_ready = ~bus.lsu_valid;

   assign w_src = wb_arbitrate(bus.lsu_valid, bus.exu_valid);

   always_comb begin
      w_fire = 1'b0;
      w_rd   = '0;
      w_data = '0;
      case (w_src)
         SRC_LSU: begin
            w_fire = 1'b1;
            w_rd   = bus.lsu_rd;
            w_data = bus.lsu_data;
         end
         SRC_EXU: begin
            w_fire = 1'b1;
            w_rd   = bus.exu_rd;
            w_data = bus.exu_data;
         end
         default: ;
      endcase
   end

   // gpr_rd must be zero on idle cycles: the register file writes on any nonzero index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_commit  <= 1'b0;
         r_gpr_rd     <= '0;
         r_gpr_wdata  <= '0;
         r_commit_cnt <= '0;
      end else begin
         r_wb_commit <= w_fire;
         r_gpr_rd    <= w_rd;
         r_gpr_wdata <= w_data;
         if (w_fire)
            r_commit_cnt <= r_commit_cnt + WBU_CNT_W'(1);
      end
   end

   assign bus.wb_commit  = r_wb_commit;
   assign bus.gpr_rd     = r_gpr_rd;
   assign bus.gpr_wdata  = r_gpr_wdata;
   assign bus.commit_cnt = r_commit_cnt;

   ysyx_25020042_scoreboard #(
      .REG_ADDR_LEN (REG_ADDR_LEN),
      .REGS         (REGS)
   ) u_scoreboard (
      .clk          (clk),
      .rst          (rst),
      .i_set_valid  (bus.iss_valid),
      .i_set_idx    (bus.iss_rd),
      .i_clr_valid  (r_wb_commit),
      .i_clr_idx    (r_gpr_rd),
      .i_rs1        (bus.rs1),
      .i_rs2        (bus.rs2),
      .o_rs1_busy   (bus.rs1_busy),
      .o_rs2_busy   (bus.rs2_busy)
   );

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25020042_wbu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25020042_wbu
// Brief    : Scoreboard-driven self-checking bench for the writeback unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_25020042_wbu;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic rst;
   exp_t q[$];
   logic [31:0] exp_cnt;
   int n_checks;
   int n_pass;

   ysyx_25020042_wbu_if #(.REG_ADDR_LEN(5), .WIDTH(32)) bus ();

   ysyx_25020042_wbu #(.REG_ADDR_LEN(5), .WIDTH(32), .REGS(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.exu_valid = 1'b0;
      bus.lsu_valid = 1'b0;
      bus.iss_valid = 1'b0;
   endtask

   task automatic push(input logic [4:0] rd, input logic [31:0] data);
      exp_t e;
      e.rd = rd;
      e.data = data;
      q.push_back(e);
      exp_cnt = exp_cnt + 32'd1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      bus.exu_rd = '0; bus.exu_data = '0; bus.lsu_rd = '0; bus.lsu_data = '0;
      bus.iss_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
      tick(); tick();
      n_checks++;
      if (bus.wb_commit !== 1'b0 || bus.gpr_rd !== 5'd0 || bus.gpr_wdata !== 32'd0 || bus.commit_cnt !== 32'd0)
         $display("FAIL reset_state: commit=%b rd=%0d wdata=%h cnt=%h, required all 0",
                  bus.wb_commit, bus.gpr_rd, bus.gpr_wdata, bus.commit_cnt);
      else n_pass++;
      n_checks++;
      if (bus.lsu_ready !== 1'b1 || bus.exu_ready !== 1'b1)
         $display("FAIL reset_ready: lsu_ready=%b exu_ready=%b, required 1/1", bus.lsu_ready, bus.exu_ready);
      else n_pass++;
      rst = 1'b0;
      exp_cnt = 32'd0;
      tick();
   endtask

   task automatic test_exu_single();
      exp_t e;
      bus.exu_valid = 1'b1; bus.exu_rd = 5'd5; bus.exu_data = 32'h1234;
      push(5'd5, 32'h1234);
      tick();
      idle();
      n_checks++;
      if (bus.wb_commit !== 1'b1 || q.size() == 0) begin
         $display("FAIL exu_single_commit: wb_commit=%b queued=%0d, required 1", bus.wb_commit, q.size());
      end else begin
         e = q.pop_front();
         if (bus.gpr_rd !== e.rd || bus.gpr_wdata !== e.data || bus.commit_cnt !== exp_cnt)
            $display("FAIL exu_single_data: rd=%0d data=%h cnt=%h, required rd=%0d data=%h cnt=%h",
                     bus.gpr_rd, bus.gpr_wdata, bus.commit_cnt, e.rd, e.data, exp_cnt);
         else n_pass++;
      end
      tick();
      n_checks++;
      if (bus.gpr_rd !== 5'd0 || bus.wb_commit !== 1'b0)
         $display("FAIL exu_idle_after: rd=%0d commit=%b, required 0/0", bus.gpr_rd, bus.wb_commit);
      else n_pass++;
   endtask

   task automatic test_lsu_priority();
      exp_t e;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'hAA;
      bus.exu_valid = 1'b1; bus.exu_rd = 5'd4; bus.exu_data = 32'hBB;
      #1;
      n_checks++;
      if (bus.exu_ready !== 1'b0 || bus.lsu_ready !== 1'b1)
         $display("FAIL prio_ready: exu_ready=%b lsu_ready=%b, required 0/1", bus.exu_ready, bus.lsu_ready);
      else n_pass++;
      push(5'd3, 32'hAA);
      tick();
      bus.lsu_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.wb_commit !== 1'b1 || q.size() == 0) begin
         $display("FAIL prio_lsu_commit: wb_commit=%b queued=%0d, required 1", bus.wb_commit, q.size());
      end else begin
         e = q.pop_front();
         if (bus.gpr_rd !== e.rd || bus.gpr_wdata !== e.data || bus.exu_ready !== 1'b1)
            $display("FAIL prio_lsu_data: rd=%0d data=%h exu_ready=%b, required rd=%0d data=%h exu_ready=1",
                     bus.gpr_rd, bus.gpr_wdata, bus.exu_ready, e.rd, e.data);
         else n_pass++;
      end
      push(5'd4, 32'hBB);
      tick();
      idle();
      n_checks++;
      if (bus.wb_commit !== 1'b1 || q.size() == 0) begin
         $display("FAIL prio_exu_commit: wb_commit=%b queued=%0d, required 1", bus.wb_commit, q.size());
      end else begin
         e = q.pop_front();
         if (bus.gpr_rd !== e.rd || bus.gpr_wdata !== e.data || bus.commit_cnt !== exp_cnt)
            $display("FAIL prio_exu_data: rd=%0d data=%h cnt=%h, required rd=%0d data=%h cnt=%h",
                     bus.gpr_rd, bus.gpr_wdata, bus.commit_cnt, e.rd, e.data, exp_cnt);
         else n_pass++;
      end
      tick();
   endtask

   task automatic test_hazard();
      exp_t e;
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
      tick();
      idle();
      bus.rs1 = 5'd7; bus.rs2 = 5'd7;
      #1;
      n_checks++;
      if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b1)
         $display("FAIL hazard_set: rs1_busy=%b rs2_busy=%b, required 1/1", bus.rs1_busy, bus.rs2_busy);
      else n_pass++;
      bus.exu_valid = 1'b1; bus.exu_rd = 5'd7; bus.exu_data = 32'h77;
      push(5'd7, 32'h77);
      tick();
      idle();
      #1;
      n_checks++;
      if (bus.wb_commit !== 1'b1 || q.size() == 0) begin
         $display("FAIL hazard_commit: wb_commit=%b queued=%0d, required 1", bus.wb_commit, q.size());
      end else begin
         e = q.pop_front();
         if (bus.gpr_rd !== e.rd || bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0)
            $display("FAIL hazard_bypass: rd=%0d rs1_busy=%b rs2_busy=%b, required rd=%0d busy 0/0",
                     bus.gpr_rd, bus.rs1_busy, bus.rs2_busy, e.rd);
         else n_pass++;
      end
      tick();
      n_checks++;
      if (bus.rs1_busy !== 1'b0)
         $display("FAIL hazard_cleared: rs1_busy=%b, required 0", bus.rs1_busy);
      else n_pass++;
      // re-issue, then commit rd7 while issuing rd7 again in the same cycle
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
      tick();
      bus.iss_valid = 1'b0;
      bus.exu_valid = 1'b1; bus.exu_rd = 5'd7; bus.exu_data = 32'h99;
      push(5'd7, 32'h99);
      tick();
      bus.exu_valid = 1'b0;
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
      #1;
      n_checks++;
      if (bus.wb_commit !== 1'b1 || q.size() == 0) begin
         $display("FAIL hazard_race_commit: wb_commit=%b queued=%0d, required 1", bus.wb_commit, q.size());
      end else begin
         e = q.pop_front();
         if (bus.gpr_rd !== e.rd || bus.gpr_wdata !== e.data || bus.rs1_busy !== 1'b0)
            $display("FAIL hazard_race_bypass: rd=%0d data=%h rs1_busy=%b, required rd=%0d data=%h busy 0",
                     bus.gpr_rd, bus.gpr_wdata, bus.rs1_busy, e.rd, e.data);
         else n_pass++;
      end
      tick();
      idle();
      #1;
      n_checks++;
      if (bus.rs1_busy !== 1'b1)
         $display("FAIL hazard_set_wins: rs1_busy=%b, required 1", bus.rs1_busy);
      else n_pass++;
      bus.exu_valid = 1'b1; bus.exu_rd = 5'd7; bus.exu_data = 32'h0;
      push(5'd7, 32'h0);
      tick();
      idle();
      e = q.pop_front();
      tick();
      n_checks++;
      if (bus.rs1_busy !== 1'b0)
         $display("FAIL hazard_final_clear: rs1_busy=%b, required 0", bus.rs1_busy);
      else n_pass++;
      bus.rs1 = 5'd0; bus.rs2 = 5'd0;
   endtask

   task automatic test_rd_zero();
      exp_t e;
      bus.exu_valid = 1'b1; bus.exu_rd = 5'd0; bus.exu_data = 32'hFFFF_FFFF;
      push(5'd0, 32'hFFFF_FFFF);
      tick();
      idle();
      n_checks++;
      if (bus.wb_commit !== 1'b1 || q.size() == 0) begin
         $display("FAIL rd0_commit: wb_commit=%b queued=%0d, required 1", bus.wb_commit, q.size());
      end else begin
         e = q.pop_front();
         if (bus.gpr_rd !== e.rd || bus.commit_cnt !== exp_cnt)
            $display("FAIL rd0_data: rd=%0d cnt=%h, required rd=%0d cnt=%h", bus.gpr_rd, bus.commit_cnt, e.rd, exp_cnt);
         else n_pass++;
      end
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
      tick();
      idle();
      bus.rs1 = 5'd0;
      #1;
      n_checks++;
      if (bus.rs1_busy !== 1'b0)
         $display("FAIL rd0_busy: rs1_busy=%b, required 0", bus.rs1_busy);
      else n_pass++;
   endtask

   task automatic test_wrap();
      exp_t e;
      force dut.r_commit_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.r_commit_cnt;
      exp_cnt = 32'hFFFF_FFFE;
      for (int i = 0; i < 2; i++) begin
         bus.exu_valid = 1'b1; bus.exu_rd = 5'd9; bus.exu_data = 32'h100 + i;
         push(5'd9, 32'h100 + i);
         tick();
         idle();
         n_checks++;
         if (bus.wb_commit !== 1'b1 || q.size() == 0) begin
            $display("FAIL wrap_commit%0d: wb_commit=%b queued=%0d, required 1", i, bus.wb_commit, q.size());
         end else begin
            e = q.pop_front();
            if (bus.commit_cnt !== exp_cnt || bus.gpr_wdata !== e.data)
               $display("FAIL wrap_cnt%0d: cnt=%h data=%h, required cnt=%h data=%h",
                        i, bus.commit_cnt, bus.gpr_wdata, exp_cnt, e.data);
            else n_pass++;
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      bus.exu_valid = 1'b1; bus.exu_rd = 5'($urandom_range(1, 31)); bus.exu_data = $urandom;
      for (int i = 0; i < 9; i++) begin
         if (i % 3 == 1) begin
            bus.lsu_valid = 1'b1; bus.lsu_rd = 5'($urandom_range(0, 31)); bus.lsu_data = $urandom;
            push(bus.lsu_rd, bus.lsu_data);
         end else begin
            bus.lsu_valid = 1'b0;
            push(bus.exu_rd, bus.exu_data);
         end
         tick();
         if (i % 3 != 1) begin
            bus.exu_rd = 5'($urandom_range(1, 31)); bus.exu_data = $urandom;
         end
         n_checks++;
         if (bus.wb_commit !== 1'b1 || q.size() == 0) begin
            $display("FAIL b2b_commit%0d: wb_commit=%b queued=%0d, required 1", i, bus.wb_commit, q.size());
         end else begin
            e = q.pop_front();
            if (bus.gpr_rd !== e.rd || (e.rd != 5'd0 && bus.gpr_wdata !== e.data) || bus.commit_cnt !== exp_cnt)
               $display("FAIL b2b_data%0d: rd=%0d data=%h cnt=%h, required rd=%0d data=%h cnt=%h",
                        i, bus.gpr_rd, bus.gpr_wdata, bus.commit_cnt, e.rd, e.data, exp_cnt);
            else n_pass++;
         end
      end
      idle();
      tick();
      n_checks++;
      if (q.size() != 0 || bus.wb_commit !== 1'b0)
         $display("FAIL b2b_drain: queued=%0d wb_commit=%b, required 0/0", q.size(), bus.wb_commit);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd12;
      bus.exu_valid = 1'b1; bus.exu_rd = 5'd11; bus.exu_data = 32'hCAFE;
      tick();
      bus.iss_valid = 1'b0;
      bus.rs1 = 5'd12;
      #2;
      rst = 1'b1;
      bus.lsu_valid = 1'b1;
      #1;
      n_checks++;
      if (bus.wb_commit !== 1'b0 || bus.gpr_rd !== 5'd0 || bus.gpr_wdata !== 32'd0 ||
          bus.commit_cnt !== 32'd0 || bus.rs1_busy !== 1'b0)
         $display("FAIL async_reset: commit=%b rd=%0d wdata=%h cnt=%h busy=%b, required all 0",
                  bus.wb_commit, bus.gpr_rd, bus.gpr_wdata, bus.commit_cnt, bus.rs1_busy);
      else n_pass++;
      n_checks++;
      if (bus.exu_ready !== 1'b0 || bus.lsu_ready !== 1'b1)
         $display("FAIL reset_comb_ready: exu_ready=%b lsu_ready=%b, required 0/1", bus.exu_ready, bus.lsu_ready);
      else n_pass++;
      tick();
      q.delete();
      exp_cnt = 32'd0;
      idle();
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (bus.wb_commit !== 1'b0 || bus.commit_cnt !== exp_cnt)
            $display("FAIL post_reset%0d: wb_commit=%b cnt=%h, required 0/%h", i, bus.wb_commit, bus.commit_cnt, exp_cnt);
         else n_pass++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      exp_cnt  = 32'd0;
      test_reset();
      test_exu_single();
      test_lsu_priority();
      test_hazard();
      test_rd_zero();
      test_wrap();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ysyx_25020042_wbu.md
YSYX_25020042_WBU -- requirements
Module: ysyx_25020042_wbu

Interface
REQ-001 SHALL have parameter REG_ADDR_LEN, default 5, register-index width.
REQ-002 SHALL have parameter WIDTH, default 32, datapath width.
REQ-003 SHALL have parameter REGS, default 32, architectural register count.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports exu_valid/exu_ready  input/output  1/1  ALU writeback handshake.
REQ-007 SHALL have ports exu_rd, exu_data  input  REG_ADDR_LEN/WIDTH  ALU destination index and result.
REQ-008 SHALL have ports lsu_valid/lsu_ready  input/output  1/1  load writeback handshake.
REQ-009 SHALL have ports lsu_rd, lsu_data  input  REG_ADDR_LEN/WIDTH  load destination index and data.
REQ-010 SHALL have ports iss_valid, iss_rd  input  1/REG_ADDR_LEN  issue marks iss_rd as pending-write.
REQ-011 SHALL have ports rs1, rs2  input  REG_ADDR_LEN  source indices for hazard query.
REQ-012 SHALL have ports rs1_busy, rs2_busy  output  1/1  combinational pending-write flags.
REQ-013 SHALL have ports gpr_rd, gpr_wdata  output  REG_ADDR_LEN/WIDTH  register-file write port; index 0 means no write.
REQ-014 SHALL have ports wb_commit, commit_cnt  output  1/32  commit pulse and running commit count.

Function
REQ-015 SHALL register the selected request into an output stage: gpr_rd/gpr_wdata/wb_commit valid exactly one cycle after the accepting handshake.
REQ-016 SHALL drive gpr_rd = 0 in every cycle with no commit, because the register file writes unconditionally whenever its index is nonzero.
REQ-017 SHALL hold lsu_ready = 1 permanently; LSU has fixed priority.
REQ-018 SHALL drive exu_ready = !lsu_valid (combinational); EXU transfer occurs only when exu_valid and exu_ready.
REQ-019 SHALL, with both valid in one cycle, accept LSU, stall EXU, and accept EXU in the next cycle that lsu_valid is low.
REQ-020 SHALL assert wb_commit for one cycle per accepted request, including requests with rd = 0 (architectural no-op, still counted).
REQ-021 SHALL increment commit_cnt by 1 on each wb_commit, wrapping modulo 2^32 from 0xFFFFFFFF to 0.
REQ-022 SHALL keep a REGS-bit busy vector: bit iss_rd set on iss_valid; bit gpr_rd cleared in the commit cycle.
REQ-023 SHALL never set busy bit 0; rs1_busy/rs2_busy for index 0 SHALL read 0.
REQ-024 SHALL let set win over clear when iss_rd equals the committing gpr_rd in the same cycle.
REQ-025 SHALL compute rsN_busy = busy[rsN] & !(wb_commit & gpr_rd == rsN), so a committing write bypasses the hazard in its commit cycle.
REQ-026 SHALL not check data for X; a request with rd = 0 and nonzero data produces gpr_rd = 0.

Reset
REQ-027 SHALL, on rst high, immediately clear gpr_rd, gpr_wdata, wb_commit, commit_cnt and the busy vector to 0, independent of clk.
REQ-028 SHALL discard any request accepted in the cycle rst rises; no commit follows reset release.
REQ-029 SHALL keep lsu_ready = 1 and exu_ready = !lsu_valid during reset (combinational); handshakes during reset are dropped.

Structure
REQ-030 SHALL place REG_ADDR_LEN, WIDTH, REGS defaults and the commit-counter width in the shared core package.
REQ-031 SHALL implement the busy vector with hazard query as one sub-module, ysyx_25020042_scoreboard; arbitration and output stage stay in the top.

Verification
REQ-032 SHALL cover exu_valid=1, rd=5, data=0x1234 -> next cycle gpr_rd=5, gpr_wdata=0x1234, wb_commit=1, commit_cnt=1; following idle cycle gpr_rd=0.
REQ-033 SHALL cover lsu(rd=3,0xAA) and exu(rd=4,0xBB) valid together -> exu_ready=0; commits rd3/0xAA then rd4/0xBB on consecutive cycles.
REQ-034 SHALL cover iss rd=7 -> rs1=7 busy=1; commit rd=7 -> rs1_busy=0 in commit cycle; same-cycle iss rd=7 with commit rd=7 -> busy stays 1 next cycle.
REQ-035 SHALL cover exu rd=0, data=0xFFFFFFFF -> gpr_rd=0, wb_commit=1, commit_cnt increments; iss rd=0 -> rs1=0 busy=0.
REQ-036 SHALL cover commit_cnt preset near 0xFFFFFFFF (via 2^32-1 commits or forced) -> next commit wraps to 0.
REQ-037 SHALL cover rst asserted mid-stream between clock edges -> all outputs 0 immediately; no wb_commit after release until a new handshake.
